// File: rtl/counters_pkg.sv
// -----------------------------------------------------------------------------
// counters_pkg
//   Shared definitions for the counter block library: the state encoding used
//   by the loadable timers and the default data/count width.
// -----------------------------------------------------------------------------
package counters_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage : counters_pkg

// File: rtl/counter_down_reload.sv
// -----------------------------------------------------------------------------
// counter_down_reload
//   Loadable down-counter / interval timer. A loaded value is counted down to
//   zero on qualified ticks, with a one-cycle terminal-count pulse. Operates as
//   a one-shot (ends in DONE) or periodic (auto-reload from the reload register).
//
// Ports
//   clk      : clock, all logic on posedge
//   rst      : synchronous, active-low reset
//   load     : capture data into count and reload register
//   data     : load value
//   start    : IDLE/DONE -> RUN (DONE restarts from the reload value)
//   stop     : RUN -> IDLE, count holds
//   en       : tick enable, only meaningful in RUN
//   periodic : 1 = auto-reload at zero, 0 = one-shot; sampled at each tick
//   count    : current count (registered)
//   tc       : terminal-count pulse, one cycle wide
//   busy     : state is RUN
//   done     : state is DONE
// -----------------------------------------------------------------------------
module counter_down_reload
  import counters_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             periodic,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] reload_d;
  state_t           state_q;
  state_t           state_d;
  logic             tc_q;
  logic             tc_d;
  logic             busy_q;
  logic             done_q;

  // Next-state / next-count decode, priority load > stop > start > tick.
  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    state_d  = state_q;
    tc_d     = 1'b0;

    if (load) begin
      count_d  = data;
      reload_d = data;
      // Load never ticks; stop still beats start, and a load out of DONE
      // parks the timer in IDLE unless it is also being started.
      if (stop) begin
        state_d = ST_IDLE;
      end else if (start) begin
        state_d = ST_RUN;
      end else if (state_q == ST_DONE) begin
        state_d = ST_IDLE;
      end else begin
        state_d = state_q;
      end
    end else if (stop) begin
      if (state_q == ST_RUN) begin
        state_d = ST_IDLE;
      end else begin
        state_d = state_q;
      end
    end else if (start) begin
      case (state_q)
        ST_IDLE: state_d = ST_RUN;
        ST_DONE: begin
          state_d = ST_RUN;
          count_d = reload_q;
        end
        ST_RUN:  state_d = state_q;
        default: state_d = ST_IDLE;
      endcase
    end else if ((state_q == ST_RUN) && en) begin
      if (count_q == CNT_ZERO) begin
        // Zero here means either a start at 0 or the periodic wrap point.
        if (periodic) begin
          count_d = reload_q;
          tc_d    = (reload_q == CNT_ZERO);
        end else begin
          tc_d    = 1'b1;
          state_d = ST_DONE;
        end
      end else if (count_q == CNT_ONE) begin
        count_d = CNT_ZERO;
        tc_d    = 1'b1;
        if (periodic) begin
          state_d = state_q;
        end else begin
          state_d = ST_DONE;
        end
      end else begin
        count_d = count_q - CNT_ONE;
      end
    end else begin
      count_d = count_q;
    end
  end

  // State, count, reload and output registers; busy/done follow the next state
  // so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q  <= CNT_ZERO;
      reload_q <= CNT_ZERO;
      state_q  <= ST_IDLE;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      state_q  <= state_d;
      tc_q     <= tc_d;
      busy_q   <= (state_d == ST_RUN);
      done_q   <= (state_d == ST_DONE);
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule : counter_down_reload

// File: tb/tb_counter_down_reload.sv
// -----------------------------------------------------------------------------
// tb_counter_down_reload
//   Directed scenarios plus randomized traffic, each cycle compared against a
//   behavioural model of the timer kept in the bench.
// -----------------------------------------------------------------------------
module tb_counter_down_reload;

  localparam int W = 8;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic         clk;
  logic         rst;
  logic         load;
  logic [W-1:0] data;
  logic         start;
  logic         stop;
  logic         en;
  logic         periodic;
  logic [W-1:0] count;
  logic         tc;
  logic         busy;
  logic         done;

  int err_cnt;
  int chk_cnt;

  // Behavioural model state.
  int m_count;
  int m_reload;
  int m_st;
  int m_tc;

  counter_down_reload #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .data     (data),
    .start    (start),
    .stop     (stop),
    .en       (en),
    .periodic (periodic),
    .count    (count),
    .tc       (tc),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Apply this cycle's inputs to the model, following the timer's rules.
  task automatic model_step();
    m_tc = 0;
    if (!rst) begin
      m_count = 0; m_reload = 0; m_st = M_IDLE;
    end else if (load) begin
      m_count  = data;
      m_reload = data;
      if (stop)                m_st = M_IDLE;
      else if (start)          m_st = M_RUN;
      else if (m_st == M_DONE) m_st = M_IDLE;
    end else if (stop) begin
      if (m_st == M_RUN) m_st = M_IDLE;
    end else if (start) begin
      if (m_st == M_DONE) begin
        m_count = m_reload;
        m_st    = M_RUN;
      end else if (m_st == M_IDLE) begin
        m_st = M_RUN;
      end
    end else if (m_st == M_RUN && en) begin
      if (m_count > 0) begin
        m_count = m_count - 1;
        if (m_count == 0) begin
          m_tc = 1;
          if (!periodic) m_st = M_DONE;
        end
      end else if (periodic) begin
        m_count = m_reload;
        m_tc    = (m_reload == 0);
      end else begin
        m_tc = 1;
        m_st = M_DONE;
      end
    end
  endtask

  // One clock: inputs already driven; update model at the edge, compare after.
  task automatic cyc(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_val({tag, "_count"}, count, m_count);
    check_val({tag, "_tc"},    tc,    m_tc);
    check_val({tag, "_busy"},  busy,  (m_st == M_RUN));
    check_val({tag, "_done"},  done,  (m_st == M_DONE));
    if (tc) check_val({tag, "_tc_at_zero"}, count, 0);
  endtask

  task automatic quiet();
    load = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    err_cnt = 0; chk_cnt = 0;
    m_count = 0; m_reload = 0; m_st = M_IDLE; m_tc = 0;
    rst = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
    en = 1'b0; periodic = 1'b0; data = 8'd0;

    // 1: reset, one-shot count from 3.
    cyc("rst"); cyc("rst");
    check_val("rst_count_lit", count, 0);
    rst = 1'b1;
    load = 1'b1; data = 8'd3; cyc("t1_load");
    quiet(); start = 1'b1; cyc("t1_start");
    quiet(); en = 1'b1;
    for (int i = 0; i < 6; i++) cyc("t1_run");
    check_val("t1_done_lit", done, 1);
    check_val("t1_busy_lit", busy, 0);

    // 4: restart from DONE reloads 3, then load 7 out of DONE.
    start = 1'b1; cyc("t4_restart");
    quiet();
    check_val("t4_reload_lit", count, 3);
    for (int i = 0; i < 5; i++) cyc("t4_run");
    load = 1'b1; data = 8'd7; cyc("t4_load");
    quiet();
    check_val("t4_load_count_lit", count, 7);
    check_val("t4_load_done_lit", done, 0);

    // 2: periodic reload from 2.
    periodic = 1'b1;
    load = 1'b1; data = 8'd2; cyc("t2_load");
    quiet(); start = 1'b1; cyc("t2_start");
    quiet();
    for (int i = 0; i < 10; i++) cyc("t2_run");
    check_val("t2_busy_lit", busy, 1);

    // 3: periodic from 5, en toggling, stop at 3, resume.
    load = 1'b1; data = 8'd5; en = 1'b0; cyc("t3_load");
    quiet(); start = 1'b1; cyc("t3_start");
    quiet();
    for (int i = 0; i < 40 && m_count != 3; i++) begin
      en = i[0];
      cyc("t3_run");
    end
    stop = 1'b1; en = 1'b1; cyc("t3_stop");
    quiet();
    check_val("t3_hold_lit", count, 3);
    check_val("t3_idle_lit", busy, 0);
    for (int i = 0; i < 3; i++) cyc("t3_idle");
    start = 1'b1; cyc("t3_resume");
    quiet();
    for (int i = 0; i < 4; i++) cyc("t3_run2");

    // 5a: load 0 + start one-shot.
    periodic = 1'b0;
    load = 1'b1; start = 1'b1; data = 8'd0; cyc("t5a_ldst");
    quiet(); cyc("t5a_tick");
    check_val("t5a_tc_lit", tc, 1);
    check_val("t5a_done_lit", done, 1);

    // 5b: periodic reload 0, tc every tick.
    periodic = 1'b1;
    load = 1'b1; start = 1'b1; cyc("t5b_ldst");
    quiet();
    for (int i = 0; i < 4; i++) begin
      cyc("t5b_tick");
      check_val("t5b_tc_lit", tc, 1);
    end

    // 5c: reload during RUN at count 4.
    periodic = 1'b0;
    load = 1'b1; start = 1'b1; data = 8'd20; cyc("t5c_ldst");
    quiet();
    for (int i = 0; i < 30 && m_count != 4; i++) cyc("t5c_run");
    load = 1'b1; data = 8'd9; cyc("t5c_reload");
    quiet();
    check_val("t5c_count_lit", count, 9);
    check_val("t5c_busy_lit", busy, 1);

    // 6: reset mid-count at 6 with start/load high.
    load = 1'b1; start = 1'b1; data = 8'd10; cyc("t6_ldst");
    quiet();
    for (int i = 0; i < 30 && m_count != 6; i++) cyc("t6_run");
    rst = 1'b0; load = 1'b1; start = 1'b1; data = 8'd33; cyc("t6_rst");
    check_val("t6_count_lit", count, 0);
    check_val("t6_busy_lit", busy, 0);
    rst = 1'b1; quiet();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 199) != 0);
      load  = ($urandom_range(0, 15) == 0);
      stop  = load ? 1'b0 : ($urandom_range(0, 15) == 0);
      start = ($urandom_range(0, 7) == 0);
      en    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 31) == 0) periodic = $urandom_range(0, 1);
      if ($urandom_range(0, 9) == 0) data = W'($urandom_range(0, 255));
      else                           data = W'($urandom_range(0, 9));
      cyc("rnd");
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule : tb_counter_down_reload
